vga_sync_decoder: RTL
=====================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameters H_FP/H_SYNC/H_BP, 16/96/48, horizontal front porch/sync/back porch in pixels; H_TOTAL = sum = 800.
REQ-003 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical in lines; V_TOTAL = 525.
REQ-004 clk  input  1  pixel clock, same clock that drives vga_controller; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 HSYNC, VSYNC  input  1 each  sync pulses, active-low.
REQ-007 RED, GRN, BLU  input  10 each  pixel colour.
REQ-008 x, y  output  11 each  recovered active-area coordinates.
REQ-009 px_data  output  30  {RED,GRN,BLU} captured for (x,y).
REQ-010 px_valid  output  1  px_data/x/y valid for an active pixel while locked.
REQ-011 line_start, frame_start  output  1 each  one-cycle pulses on HSYNC / VSYNC falling edge.
REQ-012 locked  output  1  timing verified for one full clean frame.
REQ-013 h_err, v_err  output  1 each  one-cycle error pulses.
REQ-014 err_cnt  output  8  saturating error count.

Function
REQ-015 All inputs SHALL pass through one register stage; edges are detected on registered samples; x/y/px_data/px_valid SHALL appear exactly 2 clk after the pixel is present on the pins.
REQ-016 hcnt (11 bit) SHALL load 0 on the sample holding an HSYNC falling edge, else increment, saturating at 2047.
REQ-017 HSYNC's rising edge SHALL occur on the sample with hcnt == H_SYNC; otherwise h_err pulses.
REQ-018 A falling edge with previous hcnt != H_TOTAL-1 SHALL pulse h_err (first edge after SEARCH exempt).
REQ-019 hcnt reaching 2*H_TOTAL without an HSYNC falling edge SHALL pulse h_err once and force SEARCH.
REQ-020 vcnt (11 bit) SHALL load 0 on a VSYNC falling edge, else increment on each HSYNC falling edge, saturating at 2047; coincident edges load 0.
REQ-021 VSYNC rising edge SHALL occur with vcnt == V_SYNC, and a VSYNC falling edge with vcnt != V_TOTAL-1 SHALL pulse v_err (first edge after SEARCH exempt).
REQ-022 Active pixel: H_SYNC+H_BP <= hcnt < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP <= vcnt < V_SYNC+V_BP+V_ACTIVE; x = hcnt-(H_SYNC+H_BP), y = vcnt-(V_SYNC+V_BP).
REQ-023 px_valid SHALL be 1 only for active pixels in state LOCKED; x, y, px_data SHALL hold last value when px_valid is 0.
REQ-024 Lock FSM states SEARCH, ALIGN, LOCKED; SEARCH->ALIGN on VSYNC falling edge.
REQ-025 ALIGN->LOCKED on next VSYNC falling edge if no h_err/v_err during the frame; an error restarts ALIGN at the next VSYNC falling edge.
REQ-026 LOCKED->ALIGN on any h_err or v_err; timeout (REQ-019) goes to SEARCH from any state; locked = (state == LOCKED).
REQ-027 err_cnt SHALL increment by 1 per cycle where h_err or v_err is 1 (both in one cycle count once), saturating at 255.

Reset
REQ-028 While rst is 0: state SEARCH, hcnt, vcnt, x, y, px_data, err_cnt = 0; px_valid, locked, line_start, frame_start, h_err, v_err = 0; input registers = 1 for syncs, 0 for colour.
REQ-029 Reset deassertion mid-frame SHALL need a full VSYNC-to-VSYNC clean frame after the first VSYNC edge before locked rises.

Structure
REQ-030 Timing constants and derived totals (H_TOTAL, V_TOTAL, active offsets) SHALL reside in a shared vga_timing package used by vga_controller and this block.
REQ-031 The falling/rising edge detection SHALL be one sub-module, edge_detect, instantiated for HSYNC and VSYNC.

Verification
REQ-032 Drive vga_controller output into block from reset -> locked rises at the second VSYNC falling edge (ALIGN frame plus verified frame), h_err = v_err = 0, err_cnt = 0.
REQ-033 Locked, RGB = pixel index pattern -> px_valid at x=0,y=0 carries first active pixel 2 clk after pins; 640x480 = 307200 px_valid cycles per frame.
REQ-034 Locked, shorten one line to 799 clocks -> single h_err, err_cnt = 1, state ALIGN, locked = 0; relocks after next clean frame.
REQ-035 Hold HSYNC high 1600 clocks -> one h_err, state SEARCH, px_valid = 0.
REQ-036 Frame of 524 lines -> v_err at VSYNC falling edge, locked = 0.
REQ-037 Force 300 errors -> err_cnt = 255; pulse rst low mid-line -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, derived-total helpers and common types for the
// controller and the sync decoder.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    localparam int unsigned CNT_W = 11;
    localparam int unsigned CLR_W = 10;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic [CLR_W-1:0] red;
        logic [CLR_W-1:0] grn;
        logic [CLR_W-1:0] blu;
    } pix_t;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } lock_st_e;

    localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    function automatic int unsigned line_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    // Offset of the first visible pixel/line measured from the sync falling edge.
    function automatic int unsigned active_ofs(input int unsigned sync, input int unsigned bp);
        return sync + bp;
    endfunction

    function automatic cnt_t cnt_sat_inc(input cnt_t c);
        return (c == '1) ? c : c + cnt_t'(1);
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising/falling edge detector on an already-registered sample; edges are
// combinational in the same cycle as the new sample, no backpressure.
module edge_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic fall,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = sig;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= RST_VAL;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign fall = prev_q & ~sig;
    assign rise = ~prev_q & sig;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers VGA timing, verifies it and emits active-area pixels with coordinates;
// latency 2 clk from pins to px outputs, free-running video so no backpressure.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HSYNC,
    input  logic        VSYNC,
    input  logic [9:0]  RED,
    input  logic [9:0]  GRN,
    input  logic [9:0]  BLU,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic [29:0] px_data,
    output logic        px_valid,
    output logic        line_start,
    output logic        frame_start,
    output logic        locked,
    output logic        h_err,
    output logic        v_err,
    output logic [7:0]  err_cnt
);

    localparam int unsigned H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned H_OFS   = active_ofs(H_SYNC, H_BP);
    localparam int unsigned V_OFS   = active_ofs(V_SYNC, V_BP);

    localparam cnt_t H_SYNC_C = cnt_t'(H_SYNC);
    localparam cnt_t H_LAST_C = cnt_t'(H_TOTAL - 1);
    localparam cnt_t H_TMO_C  = cnt_t'(2 * H_TOTAL);
    localparam cnt_t H_OFS_C  = cnt_t'(H_OFS);
    localparam cnt_t H_END_C  = cnt_t'(H_OFS + H_ACTIVE);
    localparam cnt_t V_SYNC_C = cnt_t'(V_SYNC);
    localparam cnt_t V_LAST_C = cnt_t'(V_TOTAL - 1);
    localparam cnt_t V_OFS_C  = cnt_t'(V_OFS);
    localparam cnt_t V_END_C  = cnt_t'(V_OFS + V_ACTIVE);

    logic       hs_q, hs_d, vs_q, vs_d;
    pix_t       pix_q, pix_d;
    cnt_t       hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic       h_seen_q, h_seen_d, v_seen_q, v_seen_d;
    cnt_t       x_q, x_d, y_q, y_d;
    pix_t       px_data_q, px_data_d;
    logic       px_valid_q, px_valid_d;
    logic       line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic       h_err_q, h_err_d, v_err_q, v_err_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    lock_st_e   state_q;
    logic       frame_err_q;
    logic       locked_q;

    logic hs_fall, hs_rise, vs_fall, vs_rise;
    logic tmo, any_err, active;

    edge_detect #(.RST_VAL(1'b1)) u_hs_edge (
        .clk   (clk),
        .rst_n (rst),
        .sig   (hs_q),
        .fall  (hs_fall),
        .rise  (hs_rise)
    );

    edge_detect #(.RST_VAL(1'b1)) u_vs_edge (
        .clk   (clk),
        .rst_n (rst),
        .sig   (vs_q),
        .fall  (vs_fall),
        .rise  (vs_rise)
    );

    // hcnt_d/vcnt_d belong to the sample now in hs_q/vs_q; the _q copies are the previous sample.
    always_comb begin
        hs_d  = HSYNC;
        vs_d  = VSYNC;
        pix_d = {RED, GRN, BLU};

        hcnt_d = hs_fall ? '0 : cnt_sat_inc(hcnt_q);
        if (vs_fall) begin
            vcnt_d = '0;
        end else if (hs_fall) begin
            vcnt_d = cnt_sat_inc(vcnt_q);
        end else begin
            vcnt_d = vcnt_q;
        end

        tmo     = !hs_fall && (hcnt_d == H_TMO_C);
        h_err_d = tmo
               || (h_seen_q && hs_rise && (hcnt_d != H_SYNC_C))
               || (h_seen_q && hs_fall && (hcnt_q != H_LAST_C));
        v_err_d = v_seen_q && ((vs_rise && (vcnt_d != V_SYNC_C))
                            || (vs_fall && (vcnt_q != V_LAST_C)));
        any_err = h_err_d || v_err_d;

        // The first edge after losing sync has no trustworthy previous count.
        h_seen_d = tmo ? 1'b0 : (hs_fall ? 1'b1 : h_seen_q);
        v_seen_d = tmo ? 1'b0 : (vs_fall ? 1'b1 : v_seen_q);

        active = (hcnt_d >= H_OFS_C) && (hcnt_d < H_END_C)
              && (vcnt_d >= V_OFS_C) && (vcnt_d < V_END_C);
        px_valid_d = active && (state_q == LOCKED) && !any_err;
        x_d        = px_valid_d ? hcnt_d - H_OFS_C : x_q;
        y_d        = px_valid_d ? vcnt_d - V_OFS_C : y_q;
        px_data_d  = px_valid_d ? pix_q : px_data_q;

        line_start_d  = hs_fall;
        frame_start_d = vs_fall;
        err_cnt_d     = (any_err && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            pix_q         <= '0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            h_seen_q      <= 1'b0;
            v_seen_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            px_data_q     <= '0;
            px_valid_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            h_err_q       <= 1'b0;
            v_err_q       <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            pix_q         <= pix_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            h_seen_q      <= h_seen_d;
            v_seen_q      <= v_seen_d;
            x_q           <= x_d;
            y_q           <= y_d;
            px_data_q     <= px_data_d;
            px_valid_q    <= px_valid_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            h_err_q       <= h_err_d;
            v_err_q       <= v_err_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    // frame_err_q marks the frame in progress as dirty; an error on the VSYNC edge itself closes the old frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SEARCH;
            frame_err_q <= 1'b0;
            locked_q    <= 1'b0;
        end else if (tmo) begin
            state_q     <= SEARCH;
            frame_err_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (vs_fall) begin
                        state_q     <= ALIGN;
                        frame_err_q <= 1'b0;
                    end
                end
                ALIGN: begin
                    if (vs_fall) begin
                        if (!frame_err_q && !any_err) begin
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
                        end
                        frame_err_q <= 1'b0;
                    end else if (any_err) begin
                        frame_err_q <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (any_err) begin
                        state_q     <= ALIGN;
                        locked_q    <= 1'b0;
                        frame_err_q <= !vs_fall;
                    end
                end
                default: begin
                    state_q     <= SEARCH;
                    frame_err_q <= 1'b0;
                    locked_q    <= 1'b0;
                end
            endcase
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign px_data     = px_data_q;
    assign px_valid    = px_valid_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign h_err       = h_err_q;
    assign v_err       = v_err_q;
    assign err_cnt     = err_cnt_q;

endmodule
